// File: rtl/regfile_scoreboard.sv
// Architectural register file with per-register pending-write scoreboard,
// writeback bypass and a registered ID->EX operand stage (RV32I/RV32E).
module regfile_scoreboard #(
  parameter int DATA_WIDTH = 32,
  parameter bit RV32E      = 1'b1,
  parameter int PEND_W     = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [4:0]            id_rs1,
  input  logic [4:0]            id_rs2,
  input  logic [4:0]            id_rd,
  input  logic                  id_rd_wen,
  input  logic                  id_ecall,
  output logic                  ex_valid,
  input  logic                  ex_ready,
  output logic [DATA_WIDTH-1:0] ex_rdata1,
  output logic [DATA_WIDTH-1:0] ex_rdata2,
  output logic [4:0]            ex_rd,
  output logic                  ex_rd_wen,
  input  logic                  wb_valid,
  input  logic                  wb_wen,
  input  logic [4:0]            wb_waddr,
  input  logic [DATA_WIDTH-1:0] wb_wdata,
  input  logic                  flush
);

  localparam logic [4:0]        ECALL_REG = RV32E ? 5'd15 : 5'd17;
  localparam logic [PEND_W-1:0] PEND_MAX  = '1;

  logic [DATA_WIDTH-1:0] regs     [32];
  logic [PEND_W-1:0]     pend     [32];
  logic [PEND_W-1:0]     pend_nxt [32];

  logic [4:0]            rs2_eff;
  logic                  wb_hit, fire, fl_dec, rd_trk;
  logic                  blk1, blk2, rd_sat;
  logic [DATA_WIDTH-1:0] rdata1, rdata2;
  logic [PEND_W:0]       psum, pdec, psub;

  // x0 and, in RV32E, any index with bit 4 set are outside the register file
  function automatic logic legal(input logic [4:0] idx);
    return (idx != 5'd0) && !(RV32E && idx[4]);
  endfunction

  always_comb begin
    rs2_eff = id_ecall ? ECALL_REG : id_rs2;
    wb_hit  = wb_valid & wb_wen & legal(wb_waddr);
    // a source is free if a writeback this cycle retires its last pending write
    blk1 = legal(id_rs1) && (pend[id_rs1] != '0) &&
           !(wb_hit && (wb_waddr == id_rs1) && (pend[id_rs1] == PEND_W'(1)));
    blk2 = legal(rs2_eff) && (pend[rs2_eff] != '0) &&
           !(wb_hit && (wb_waddr == rs2_eff) && (pend[rs2_eff] == PEND_W'(1)));
    rd_sat   = id_rd_wen && legal(id_rd) && (pend[id_rd] == PEND_MAX);
    id_ready = (~ex_valid | ex_ready) & ~flush & ~blk1 & ~blk2 & ~rd_sat;
    fire     = id_valid & id_ready;
    rd_trk   = fire & id_rd_wen & legal(id_rd);
    fl_dec   = flush & ex_valid & ex_rd_wen & legal(ex_rd);

    rdata1 = '0;
    if (legal(id_rs1))
      rdata1 = (wb_hit && (wb_waddr == id_rs1)) ? wb_wdata : regs[id_rs1];
    rdata2 = '0;
    if (legal(rs2_eff))
      rdata2 = (wb_hit && (wb_waddr == rs2_eff)) ? wb_wdata : regs[rs2_eff];
  end

  // issue increment and writeback/flush decrements combine arithmetically, floor at 0
  always_comb begin
    psum = '0;
    pdec = '0;
    psub = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      psum = {1'b0, pend[i]} + (PEND_W+1)'(rd_trk && (id_rd == i[4:0]));
      pdec = (PEND_W+1)'(wb_hit && (wb_waddr == i[4:0])) +
             (PEND_W+1)'(fl_dec && (ex_rd == i[4:0]));
      psub = psum - pdec;
      pend_nxt[i] = (psum > pdec) ? psub[PEND_W-1:0] : '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs[i] <= '0;
        pend[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 32; i++)
        pend[i] <= pend_nxt[i];
      if (wb_hit)
        regs[wb_waddr] <= wb_wdata;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ex_valid  <= 1'b0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_rd     <= '0;
      ex_rd_wen <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (fire) begin
      ex_valid  <= 1'b1;
      ex_rdata1 <= rdata1;
      ex_rdata2 <= rdata2;
      ex_rd     <= id_rd;
      ex_rd_wen <= id_rd_wen;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: directed scenarios plus randomized traffic
// checked against a per-register count/array reference model.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        resetn;
  logic        id_valid, id_ready, id_rd_wen, id_ecall;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        ex_valid, ex_ready, ex_rd_wen;
  logic [31:0] ex_rdata1, ex_rdata2;
  logic [4:0]  ex_rd;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        flush;

  always #5 clk = ~clk;

  regfile_scoreboard #(.DATA_WIDTH(32), .RV32E(1'b1), .PEND_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .id_valid(id_valid), .id_ready(id_ready), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rd_wen(id_rd_wen), .id_ecall(id_ecall),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rdata1(ex_rdata1),
    .ex_rdata2(ex_rdata2), .ex_rd(ex_rd), .ex_rd_wen(ex_rd_wen),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .wb_wdata(wb_wdata), .flush(flush)
  );

  // reference state: register values, outstanding-write counts, EX entry
  logic [31:0] mregs [32];
  int          mpend [32];
  logic        mv, mwen;
  logic [31:0] m1, m2;
  logic [4:0]  mrd;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit legal(input int i);
    return (i != 0) && (i < 16);
  endfunction

  function automatic bit wb_to(input int s);
    return wb_valid && wb_wen && legal(int'(wb_waddr)) && (int'(wb_waddr) == s);
  endfunction

  function automatic bit m_blocked(input int s);
    if (!legal(s) || mpend[s] == 0) return 1'b0;
    return !(wb_to(s) && mpend[s] == 1);
  endfunction

  function automatic int rs2e();
    return id_ecall ? 15 : int'(id_rs2);
  endfunction

  function automatic bit m_ready();
    bit sat;
    sat = id_rd_wen && legal(int'(id_rd)) && (mpend[id_rd] == 3);
    return (!mv || ex_ready) && !flush && !m_blocked(int'(id_rs1)) &&
           !m_blocked(rs2e()) && !sat;
  endfunction

  function automatic logic [31:0] m_val(input int s);
    if (!legal(s)) return 32'h0;
    if (wb_to(s)) return wb_wdata;
    return mregs[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      mregs[i] = '0;
      mpend[i] = 0;
    end
    mv = 1'b0; mwen = 1'b0; m1 = '0; m2 = '0; mrd = '0;
  endtask

  // one clock: check id_ready mid-cycle, advance model at the edge, check EX after
  task automatic cyc();
    bit          rdy, fire;
    logic [31:0] v1, v2;
    int          p;
    #2;
    rdy = m_ready();
    check("id_ready", {31'b0, id_ready}, {31'b0, rdy});
    v1 = m_val(int'(id_rs1));
    v2 = m_val(rs2e());
    fire = id_valid && rdy;
    @(posedge clk);
    for (int i = 1; i < 16; i++) begin
      p = mpend[i];
      if (fire && id_rd_wen && int'(id_rd) == i) p++;
      if (wb_to(i)) p--;
      if (flush && mv && mwen && int'(mrd) == i) p--;
      mpend[i] = (p < 0) ? 0 : p;
    end
    if (wb_valid && wb_wen && legal(int'(wb_waddr))) mregs[wb_waddr] = wb_wdata;
    if (flush) mv = 1'b0;
    else if (fire) begin
      mv = 1'b1; m1 = v1; m2 = v2; mrd = id_rd; mwen = id_rd_wen;
    end else if (ex_ready) mv = 1'b0;
    #1;
    check("ex_valid", {31'b0, ex_valid}, {31'b0, mv});
    check("ex_rdata1", ex_rdata1, m1);
    check("ex_rdata2", ex_rdata2, m2);
    check("ex_rd", {27'b0, ex_rd}, {27'b0, mrd});
    check("ex_rd_wen", {31'b0, ex_rd_wen}, {31'b0, mwen});
  endtask

  task automatic set_id(input bit v, input int r1, input int r2, input int rd,
                        input bit wen, input bit ec);
    id_valid = v; id_rs1 = 5'(r1); id_rs2 = 5'(r2); id_rd = 5'(rd);
    id_rd_wen = wen; id_ecall = ec;
  endtask

  task automatic set_wb(input bit v, input int a, input logic [31:0] d);
    wb_valid = v; wb_wen = v; wb_waddr = 5'(a); wb_wdata = d;
  endtask

  function automatic int pick_wb_addr();
    int a;
    for (int t = 0; t < 20; t++) begin
      a = int'($urandom_range(1, 15));
      if (mpend[a] > 0) return a;
    end
    return int'($urandom_range(0, 31));
  endfunction

  initial begin
    resetn = 1'b0; ex_ready = 1'b1; flush = 1'b0;
    set_id(0, 0, 0, 0, 0, 0);
    set_wb(0, 0, 32'h0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    check("rst_ex_rdata1", ex_rdata1, 32'h0);
    check("rst_ex_rdata2", ex_rdata2, 32'h0);
    check("rst_ex_rd", {27'b0, ex_rd}, 32'h0);
    check("rst_ex_rd_wen", {31'b0, ex_rd_wen}, 32'h0);
    resetn = 1'b1;

    // RAW stall released by same-cycle writeback, value arrives through bypass
    set_id(1, 0, 0, 3, 1, 0); cyc();
    set_id(1, 3, 0, 0, 0, 0); cyc();
    set_wb(1, 3, 32'hDEADBEEF); cyc();
    check("raw_bypass", ex_rdata1, 32'hDEADBEEF);
    set_wb(0, 0, 32'h0);

    // back-pressure holds EX, then back-to-back issue
    ex_ready = 1'b0;
    repeat (4) begin
      cyc();
      check("bp_hold_data", ex_rdata1, 32'hDEADBEEF);
      check("bp_hold_valid", {31'b0, ex_valid}, 32'h1);
    end
    ex_ready = 1'b1;
    set_id(1, 0, 3, 0, 0, 0); cyc();
    check("bp_b2b_valid", {31'b0, ex_valid}, 32'h1);
    check("bp_b2b_data", ex_rdata2, 32'hDEADBEEF);

    // ecall reads x15; illegal index 20 reads zero and is never written
    set_id(1, 0, 0, 15, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0); set_wb(1, 15, 32'h5D); cyc();
    set_wb(0, 0, 32'h0);
    set_id(1, 20, 0, 0, 0, 1); cyc();
    check("ecall_x15", ex_rdata2, 32'h5D);
    check("illegal_rs1", ex_rdata1, 32'h0);
    set_id(0, 0, 0, 0, 0, 0); set_wb(1, 20, 32'h1234); cyc();
    set_wb(0, 0, 32'h0);
    set_id(1, 20, 0, 0, 0, 0); cyc();
    check("wb_illegal_ignored", ex_rdata1, 32'h0);

    // saturate pend[7], then free one slot by flushing the EX entry
    set_id(1, 0, 0, 7, 1, 0);
    repeat (3) cyc();
    ex_ready = 1'b0; cyc();
    flush = 1'b1; cyc();
    flush = 1'b0; ex_ready = 1'b1; cyc();
    check("sat_flush_issue", {31'b0, ex_valid}, 32'h1);
    check("sat_flush_rd", {27'b0, ex_rd}, 32'd7);

    // x0 is never tracked or written
    set_id(1, 0, 0, 0, 1, 0); cyc();
    set_id(1, 0, 0, 0, 0, 0); set_wb(1, 0, 32'hFFFFFFFF); cyc();
    set_wb(0, 0, 32'h0); cyc();
    check("x0_reads_zero", ex_rdata1, 32'h0);

    // asynchronous reset mid-stream
    set_id(1, 0, 0, 5, 1, 0); cyc();
    set_id(0, 0, 0, 0, 0, 0);
    #2 resetn = 1'b0;
    #1 check("async_rst_ex_valid", {31'b0, ex_valid}, 32'h0);
    model_reset();
    @(posedge clk); #1;
    resetn = 1'b1;
    set_id(1, 5, 0, 0, 0, 0); cyc();
    check("post_rst_rs1", ex_rdata1, 32'h0);
    check("post_rst_valid", {31'b0, ex_valid}, 32'h1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      set_id($urandom_range(0, 3) != 0, int'($urandom_range(0, 17)),
             int'($urandom_range(0, 17)), int'($urandom_range(0, 17)),
             $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      ex_ready = $urandom_range(0, 3) != 0;
      flush    = $urandom_range(0, 11) == 0;
      if ($urandom_range(0, 9) < 4) set_wb(1, pick_wb_addr(), $urandom);
      else set_wb(0, 0, 32'h0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor of the single-issue register file.
- Architectural register file with a per-register pending-write scoreboard, writeback-to-read bypass, and a registered ID->EX operand stage.
- Sits between decode and execute. Accepts decoded instructions on a valid/ready handshake and stalls on RAW hazards. Presents captured operands to execute on a second valid/ready handshake.
- Supports RV32I (32 regs) or RV32E (16 regs), and the ecall argument-register override.

Parameters:
- DATA_WIDTH, 32, register/data width.
- RV32E, 1, 1 = 16 architectural registers and ecall reads x15; 0 = 32 registers and ecall reads x17.
- PEND_W, 2, width of each per-register pending counter; max outstanding writes per register = 2^PEND_W-1.

Ports:
- clk  in  1  clock, all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- id_valid  in  1  decode offers an instruction.
- id_ready  out  1  instruction accepted this cycle when id_valid is also high.
- id_rs1  in  5  source 1 index.
- id_rs2  in  5  source 2 index.
- id_rd  in  5  destination index.
- id_rd_wen  in  1  instruction writes rd.
- id_ecall  in  1  replace rs2 with the ecall argument register.
- ex_valid  out  1  operand stage holds a valid entry.
- ex_ready  in  1  execute consumes the entry.
- ex_rdata1  out  DATA_WIDTH  captured source 1 value.
- ex_rdata2  out  DATA_WIDTH  captured source 2 value.
- ex_rd  out  5  captured rd.
- ex_rd_wen  out  1  captured rd write enable.
- wb_valid  in  1  writeback beat.
- wb_wen  in  1  writeback writes a register.
- wb_waddr  in  5  writeback index.
- wb_wdata  in  DATA_WIDTH  writeback data.
- flush  in  1  discard the operand-stage entry.

Behaviour:
- Reset (resetn low, asynchronous):
  - all registers = 0; all pending counters = 0.
  - ex_valid = 0; ex_rdata1/2 = 0; ex_rd = 0; ex_rd_wen = 0.
- Index legality: x0 always reads 0 and is never written or tracked. With RV32E = 1, any index with bit 4 set reads 0, is never written, and never causes a hazard.
- Effective rs2 = (RV32E ? 15 : 17) when id_ecall, else id_rs2.
- Hazard: a source is blocked when pend[src] != 0, unless a writeback this cycle (wb_valid & wb_wen & wb_waddr == src) brings pend[src] to 0.
  - rd saturation also blocks: id_rd_wen & pend[id_rd] == 2^PEND_W-1.
- id_ready = (~ex_valid | ex_ready) & ~flush & ~hazard. It is combinational and does not depend on id_valid.
- Issue fire = id_valid & id_ready. On fire, the next edge:
  - captures operands, rd and rd_wen into the EX registers;
  - sets ex_valid = 1;
  - increments pend[id_rd] if id_rd_wen and rd is legal and nonzero.
- Operand read bypass: if the same-cycle writeback matches the source index, capture wb_wdata; otherwise capture the array value.
- EX stage:
  - ex_valid & ~ex_ready holds all EX outputs stable.
  - ex_ready & ~fire clears ex_valid next edge.
  - Latency: ID fire to ex_valid is 1 cycle. Throughput is 1 per cycle without hazards.
- Writeback: wb_valid & wb_wen & legal nonzero index writes the array and decrements pend[wb_waddr] (saturates at 0; the 0 case is a protocol error).
  - Array read of the same index in the same cycle returns the old value; only the bypass provides the new value.
- Simultaneous increment and decrement of the same counter: net unchanged.
- flush:
  - next edge clears ex_valid;
  - if the discarded entry had ex_valid & ex_rd_wen with a legal nonzero rd, decrements pend[ex_rd] (combined with any same-cycle writeback decrement/issue increment arithmetically);
  - blocks issue in the same cycle.
- No combinational path from ex_ready to ex_rdata*. id_ready depends combinationally on ex_ready, flush and the wb_* ports.

Test Plan:
- Reset mid-stream: pend[5]=1 and ex_valid=1, assert resetn=0 asynchronously -> ex_valid=0 immediately. After release, pend[5]=0 and issuing rs1=5 gets id_ready=1 and ex_rdata1=0.
- RAW stall:
  - issue rd=3 wen; next cycle offer rs1=3 -> id_ready=0.
  - wb x3=0xDEADBEEF arrives -> id_ready=1 the same cycle and ex_rdata1=0xDEADBEEF via bypass.
- Back-pressure: ex_ready=0 with ex_valid=1 -> id_ready=0 and EX outputs stable for 4 cycles. ex_ready=1 plus a new issue -> back-to-back ex_valid with no bubble.
- Ecall/RV32E: RV32E=1, x15=0x5D, id_ecall=1, rs2=0 -> ex_rdata2=0x5D. rs1=20 -> ex_rdata1=0 with no stall. wb to x20 is ignored.
- Saturation and flush:
  - with PEND_W=2, three issues to rd=7 leave pend[7]=3; a fourth rd=7 issue stalls.
  - flush with ex_rd=7 -> pend[7]=2 and the fourth issue proceeds.
- x0: issue rd=0 wen, then rs1=0 -> no stall, ex_rdata1=0. wb to x0 with data 0xFFFFFFFF leaves x0 reading 0.
